// File: rtl/dual_tdm_demux.sv
// dual_tdm_demux: steps the select of an upstream dual 4:1 mux and samples both serial lanes.
// The two reassembled words go out over valid/ready. Define DEMUX_ERR_EN to add the err flag.
module dual_tdm_demux #(
  parameter  int DW = 4,
  localparam int SW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          din1,
  input  logic          din2,
  input  logic          en1_n,
  input  logic          en2_n,
  output logic [SW-1:0] sel,
  output logic [DW-1:0] q1,
  output logic [DW-1:0] q2,
  output logic          valid,
  input  logic          ready,
`ifdef DEMUX_ERR_EN
  output logic          err,
`endif
  output logic [1:0]    dbg_state
);

  // Handshake: a frame transfers on any edge where valid && ready. While valid is high and
  // ready is low, q1/q2 (and err) stay frozen. A new frame may load on the accepting edge.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STALL   = 2'd2
  } state_t;

  localparam logic [SW-1:0] LAST = SW'(DW - 1);

  state_t        state, state_n;
  logic [SW-1:0] sel_n;
  logic [DW-1:0] shadow1, shadow2, shadow1_n, shadow2_n;
  logic [DW-1:0] q1_n, q2_n;
  logic          valid_n;
  logic          load_cap, load_stall;
  logic          bit1, bit2, out_free;

  // A disabled lane is forced to 0 so a floating upstream output never enters a word.
  assign bit1      = en1_n ? 1'b0 : din1;
  assign bit2      = en2_n ? 1'b0 : din2;
  assign out_free  = !valid || ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    shadow1_n  = shadow1;
    shadow2_n  = shadow2;
    q1_n       = q1;
    q2_n       = q2;
    valid_n    = valid && !ready;
    load_cap   = 1'b0;
    load_stall = 1'b0;
    unique case (state)
      IDLE: begin
        sel_n = '0;
        if (start) state_n = CAPTURE;
      end
      CAPTURE: begin
        shadow1_n[sel] = bit1;
        shadow2_n[sel] = bit2;
        if (sel == LAST) begin
          if (out_free) begin
            load_cap = 1'b1;
            q1_n     = shadow1_n;
            q2_n     = shadow2_n;
            valid_n  = 1'b1;
            sel_n    = '0;
            state_n  = start ? CAPTURE : IDLE;
          end else begin
            state_n = STALL;
          end
        end else begin
          sel_n = sel + 1'b1;
        end
      end
      STALL: begin
        if (ready) begin
          load_stall = 1'b1;
          q1_n       = shadow1;
          q2_n       = shadow2;
          valid_n    = 1'b1;
          sel_n      = '0;
          state_n    = start ? CAPTURE : IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= '0;
      shadow1 <= '0;
      shadow2 <= '0;
      q1      <= '0;
      q2      <= '0;
      valid   <= 1'b0;
    end else begin
      sel     <= sel_n;
      shadow1 <= shadow1_n;
      shadow2 <= shadow2_n;
      q1      <= q1_n;
      q2      <= q2_n;
      valid   <= valid_n;
    end
  end

`ifdef DEMUX_ERR_EN
  logic shadow_err, frame_err;

  // The sticky flag restarts on the first select step of every frame.
  assign frame_err = ((sel == '0) ? 1'b0 : shadow_err) | en1_n | en2_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_err <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (state == CAPTURE) shadow_err <= frame_err;
      if (load_cap)         err <= frame_err;
      else if (load_stall)  err <= shadow_err;
    end
  end
`else
  logic unused_loads;
  assign unused_loads = load_cap ^ load_stall;
`endif

endmodule
